// File: rtl/idram_pkg.sv
// Shared definitions for the instruction data RAM: refill FSM states and
// helpers deriving line size and fetch-offset width from module parameters.
package idram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_DONE
    } fill_state_e;

    function automatic int unsigned line_words(input int unsigned wow);
        return 32'd1 << wow;
    endfunction

    // Offset bits consumed by bank selection within one fetch.
    function automatic int unsigned fetch_off_w(input int unsigned fw);
        return $clog2(fw);
    endfunction

endpackage

// File: rtl/idram_bank.sv
// One word-interleaved bank of the instruction RAM: single write port, one
// registered read port. Optional per-word even parity under IDRAM_PARITY_EN.
module idram_bank #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata,
    output logic          rperr
);

`ifdef IDRAM_PARITY_EN
    localparam int unsigned MW = DW + 1;
`else
    localparam int unsigned MW = DW;
`endif

    logic [MW-1:0] mem_q [1 << AW];
    logic [MW-1:0] wword;
    logic [MW-1:0] rdata_q, rdata_d;

`ifdef IDRAM_PARITY_EN
    assign wword = {^wdata, wdata};
    // Stored bit makes the whole word even, so any odd flip shows as 1.
    assign rperr = ^rdata_q;
`else
    assign wword = wdata;
    assign rperr = 1'b0;
`endif

    assign rdata = rdata_q[DW-1:0];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wword;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: rtl/idram_mw.sv
// Multi-word-fetch instruction RAM with critical-word-first line refill.
// Define IDRAM_PARITY_EN to store and check one even-parity bit per word.
`ifndef I_INDEX_WIDTH
`define I_INDEX_WIDTH 4
`endif
`ifndef I_WO_WIDTH
`define I_WO_WIDTH 2
`endif

module idram_mw
    import idram_pkg::*;
#(
    parameter int unsigned DW  = 32,
    parameter int unsigned IW  = `I_INDEX_WIDTH,
    parameter int unsigned WOW = `I_WO_WIDTH,
    parameter int unsigned FW  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd_en,
    output logic             rd_ready,
    input  logic [IW-1:0]    rd_index,
    input  logic [WOW-1:0]   rd_offset,
    output logic             rd_valid,
    output logic [DW*FW-1:0] rd_data,
    output logic             rd_perr,
    input  logic             fill_start,
    input  logic [IW-1:0]    fill_index,
    input  logic [WOW-1:0]   fill_offset,
    input  logic             fill_valid,
    input  logic [DW-1:0]    fill_data,
    output logic             fill_ready,
    output logic             fill_done
);

    localparam int unsigned LINE_W = line_words(WOW);
    localparam int unsigned FOW    = fetch_off_w(FW);
    localparam int unsigned AW     = IW + WOW - FOW;

    fill_state_e    state_q, state_d;
    logic [WOW-1:0] beat_cnt_q, beat_cnt_d;
    logic [IW-1:0]  fill_idx_q, fill_idx_d;
    logic [WOW-1:0] fill_off_q, fill_off_d;
    logic           rd_valid_q, rd_valid_d;

    logic              rd_accept;
    logic              beat_we;
    logic [WOW-1:0]    beat_off;
    logic [IW+WOW-1:0] waddr_full, raddr_full;
    logic [FW-1:0]     perr_vec;
    logic              rd_off_unused;

    assign rd_ready   = (state_q == ST_IDLE);
    assign fill_ready = (state_q == ST_FILL);
    assign fill_done  = (state_q == ST_DONE);
    assign rd_accept  = rd_en & rd_ready;
    assign beat_we    = fill_valid & fill_ready;
    // Wraps modulo the line size for critical-word-first order.
    assign beat_off   = fill_off_q + beat_cnt_q;
    assign waddr_full = {fill_idx_q, beat_off};
    assign raddr_full = {rd_index, rd_offset};
    // Low offset bits only select banks; the fetch is aligned down.
    assign rd_off_unused = ^raddr_full;

    assign rd_valid = rd_valid_q;
    assign rd_perr  = rd_valid_q & (|perr_vec);

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        fill_idx_d = fill_idx_q;
        fill_off_d = fill_off_q;
        rd_valid_d = rd_accept;
        case (state_q)
            ST_IDLE: begin
                if (fill_start) begin
                    state_d    = ST_FILL;
                    fill_idx_d = fill_index;
                    fill_off_d = fill_offset;
                    beat_cnt_d = '0;
                end
            end
            ST_FILL: begin
                if (fill_valid) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == WOW'(LINE_W - 1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            beat_cnt_q <= '0;
            fill_idx_q <= '0;
            fill_off_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            fill_idx_q <= fill_idx_d;
            fill_off_q <= fill_off_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    for (genvar b = 0; b < int'(FW); b++) begin : g_bank
        localparam int unsigned BANK = b;
        logic bank_we;

        assign bank_we = beat_we && ((32'(beat_off) % FW) == BANK);

        idram_bank #(
            .DW (DW),
            .AW (AW)
        ) u_bank (
            .clk   (clk),
            .rst   (rst),
            .we    (bank_we),
            .waddr (waddr_full[IW+WOW-1:FOW]),
            .wdata (fill_data),
            .re    (rd_accept),
            .raddr (raddr_full[IW+WOW-1:FOW]),
            .rdata (rd_data[b*DW +: DW]),
            .rperr (perr_vec[b])
        );
    end

endmodule

// File: tb/tb_idram_mw.sv
// Self-checking bench for idram_mw (DW=32, IW=4, WOW=2, FW=2): vector table
// of reads plus directed refill, reset and busy sequences, scoreboarded.
module tb_idram_mw;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_en = 1'b0;
    logic        rd_ready;
    logic [3:0]  rd_index = '0;
    logic [1:0]  rd_offset = '0;
    logic        rd_valid;
    logic [63:0] rd_data;
    logic        rd_perr;
    logic        fill_start = 1'b0;
    logic [3:0]  fill_index = '0;
    logic [1:0]  fill_offset = '0;
    logic        fill_valid = 1'b0;
    logic [31:0] fill_data = '0;
    logic        fill_ready;
    logic        fill_done;

    idram_mw #(.DW(32), .IW(4), .WOW(2), .FW(2)) u_dut (
        .clk(clk), .rst(rst),
        .rd_en(rd_en), .rd_ready(rd_ready), .rd_index(rd_index), .rd_offset(rd_offset),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_perr(rd_perr),
        .fill_start(fill_start), .fill_index(fill_index), .fill_offset(fill_offset),
        .fill_valid(fill_valid), .fill_data(fill_data),
        .fill_ready(fill_ready), .fill_done(fill_done)
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] data; logic perr; } exp_t;
    typedef struct { logic [3:0] idx; logic [1:0] off; logic [63:0] exp; } rd_vec_t;

    exp_t    sbq[$];
    rd_vec_t tbl [10];
    int      total = 0;
    int      bad = 0;

    localparam logic [31:0] A = 32'hA0A0_0001, B = 32'hB0B0_0002, C = 32'hC0C0_0003, D = 32'hD0D0_0004;
    localparam logic [31:0] P0 = 32'h5000_0010, P1 = 32'h5000_0011, P2 = 32'h5000_0012, P3 = 32'h5000_0013;
    localparam logic [31:0] Q0 = 32'h0BAD_F000, Q1 = 32'h0BAD_F001, Q2 = 32'h0BAD_F002, Q3 = 32'h0BAD_F003;
    localparam logic [31:0] R0 = 32'hFFFF_0000, R1 = 32'hFFFF_0001, R2 = 32'hFFFF_0002, R3 = 32'hFFFF_0003;
    localparam logic [31:0] N0 = 32'h1234_5670, N1 = 32'h1234_5671, N2 = 32'h1234_5672, N3 = 32'h1234_5673;
    localparam logic [31:0] S0 = 32'h7700_0000, S1 = 32'h7700_0001, S2 = 32'h7700_0002, S3 = 32'h7700_0003;
    localparam logic [31:0] X0 = 32'h3C3C_0000, X1 = 32'h3C3C_0001;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard consumer: every rd_valid must match the oldest pushed read.
    always @(posedge clk) begin
        #1;
        if (rd_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rd_valid: got data %h with no read pending", rd_data);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("rd_data", rd_data, e.data);
                chk("rd_perr", 64'(rd_perr), 64'(e.perr));
            end
        end
    end

    task automatic issue_read(input logic [3:0] idx, input logic [1:0] off,
                              input logic [63:0] exp, input logic perr);
        @(negedge clk);
        rd_en = 1'b1; rd_index = idx; rd_offset = off;
        if (rd_ready) sbq.push_back('{data: exp, perr: perr});
    endtask

    task automatic single_read(input logic [3:0] idx, input logic [1:0] off, input logic [63:0] exp);
        issue_read(idx, off, exp, 1'b0);
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic fill_begin(input logic [3:0] idx, input logic [1:0] off);
        @(negedge clk);
        fill_start = 1'b1; fill_index = idx; fill_offset = off;
        @(negedge clk);
        fill_start = 1'b0;
        chk("fill_ready_after_start", 64'(fill_ready), 64'd1);
    endtask

    task automatic fill_beats(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                              input logic [31:0] w3, input int gap, input int nbeats);
        logic [31:0] w [4];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        for (int k = 0; k < nbeats; k++) begin
            fill_valid = 1'b1; fill_data = w[k];
            @(negedge clk);
            fill_valid = 1'b0;
            if (k < 3) begin
                for (int g = 0; g < gap; g++) begin
                    chk("gap_no_done", 64'(fill_done), 64'd0);
                    chk("gap_fill_ready", 64'(fill_ready), 64'd1);
                    @(negedge clk);
                end
            end
        end
        if (nbeats == 4) begin
            chk("fill_done_pulse", 64'(fill_done), 64'd1);
            chk("done_fill_ready", 64'(fill_ready), 64'd0);
            @(negedge clk);
            chk("fill_done_single", 64'(fill_done), 64'd0);
            chk("idle_rd_ready", 64'(rd_ready), 64'd1);
        end
    endtask

    initial begin
        tbl[0] = '{4'd3,  2'd1, {D, C}};
        tbl[1] = '{4'd3,  2'd0, {D, C}};
        tbl[2] = '{4'd3,  2'd3, {B, A}};
        tbl[3] = '{4'd3,  2'd2, {B, A}};
        tbl[4] = '{4'd5,  2'd0, {P1, P0}};
        tbl[5] = '{4'd5,  2'd3, {P3, P2}};
        tbl[6] = '{4'd0,  2'd0, {Q0, Q3}};
        tbl[7] = '{4'd0,  2'd2, {Q2, Q1}};
        tbl[8] = '{4'd15, 2'd0, {R2, R1}};
        tbl[9] = '{4'd15, 2'd2, {R0, R3}};

        repeat (2) @(negedge clk);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_rd_data", rd_data, 64'd0);
        chk("rst_rd_perr", 64'(rd_perr), 64'd0);
        chk("rst_rd_ready", 64'(rd_ready), 64'd1);
        chk("rst_fill_ready", 64'(fill_ready), 64'd0);
        chk("rst_fill_done", 64'(fill_done), 64'd0);
        rst = 1'b0;

        // Critical-word-first, gapped beats, and wrap from offsets 1 and 3.
        fill_begin(4'd3, 2'd2);  fill_beats(A, B, C, D, 0, 4);
        fill_begin(4'd5, 2'd0);  fill_beats(P0, P1, P2, P3, 3, 4);
        fill_begin(4'd0, 2'd1);  fill_beats(Q0, Q1, Q2, Q3, 1, 4);
        fill_begin(4'd15, 2'd3); fill_beats(R0, R1, R2, R3, 0, 4);

        for (int i = 0; i < 10; i++) issue_read(tbl[i].idx, tbl[i].off, tbl[i].exp, 1'b0);
        @(negedge clk);
        rd_en = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("idle_valid_low", 64'(rd_valid), 64'd0);
            chk("idle_data_held", rd_data, {R0, R3});
        end

        // Read and refill start together at the same index.
        @(negedge clk);
        rd_en = 1'b1; rd_index = 4'd5; rd_offset = 2'd2;
        sbq.push_back('{data: {P3, P2}, perr: 1'b0});
        fill_start = 1'b1; fill_index = 4'd5; fill_offset = 2'd0;
        @(negedge clk);
        rd_en = 1'b0; fill_start = 1'b0;
        chk("simul_enter_fill", 64'(fill_ready), 64'd1);
        fill_beats(N0, N1, N2, N3, 0, 4);
        single_read(4'd5, 2'd2, {N3, N2});

        // Read held high across a whole refill.
        @(negedge clk);
        fill_start = 1'b1; fill_index = 4'd7; fill_offset = 2'd0;
        rd_en = 1'b1; rd_index = 4'd3; rd_offset = 2'd0;
        sbq.push_back('{data: {D, C}, perr: 1'b0});
        @(negedge clk);
        fill_start = 1'b0;
        chk("busy_rd_ready", 64'(rd_ready), 64'd0);
        for (int k = 0; k < 4; k++) begin
            fill_valid = 1'b1; fill_data = 32'h7700_0000 + 32'(k);
            @(negedge clk);
            fill_valid = 1'b0;
            chk("busy_no_valid", 64'(rd_valid), 64'd0);
            chk("busy_rd_ready_beat", 64'(rd_ready), 64'd0);
        end
        chk("busy_done", 64'(fill_done), 64'd1);
        @(negedge clk);
        chk("after_done_ready", 64'(rd_ready), 64'd1);
        sbq.push_back('{data: {D, C}, perr: 1'b0});
        @(negedge clk);
        rd_en = 1'b0;
        chk("first_accept_after_done", 64'(rd_valid), 64'd1);
        single_read(4'd7, 2'd2, {S3, S2});

        // Asynchronous reset in the middle of a read.
        @(negedge clk);
        rd_en = 1'b1; rd_index = 4'd0; rd_offset = 2'd2;
        sbq.push_back('{data: {Q2, Q1}, perr: 1'b0});
        @(posedge clk);
        #3;
        rd_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("midread_rst_valid", 64'(rd_valid), 64'd0);
        chk("midread_rst_data", rd_data, 64'd0);
        chk("midread_rst_ready", 64'(rd_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;

        // Refill aborted by reset after two beats.
        fill_begin(4'd3, 2'd0);
        fill_beats(X0, X1, 32'd0, 32'd0, 0, 2);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("midfill_rst_fill_ready", 64'(fill_ready), 64'd0);
        chk("midfill_rst_rd_ready", 64'(rd_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        single_read(4'd3, 2'd0, {X1, X0});
        single_read(4'd3, 2'd2, {B, A});

`ifdef IDRAM_PARITY_EN
        u_dut.g_bank[0].u_bank.mem_q[6][0] = ~u_dut.g_bank[0].u_bank.mem_q[6][0];
        issue_read(4'd3, 2'd1, {X1, X0 ^ 32'd1}, 1'b1);
        @(negedge clk);
        rd_en = 1'b0;
`else
        single_read(4'd15, 2'd1, {R2, R1});
`endif

        for (int i = 0; i < 20; i++) begin
            if (sbq.size() == 0) break;
            @(negedge clk);
        end
        chk("scoreboard_drain", 64'(sbq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of test expected finish");
        $fatal(1);
    end

endmodule

// File: doc/idram_mw.md
IDRAM_MW -- requirements
Module: idram_mw

Interface
REQ-001 SHALL have parameter DW, default 32, word width in bits.
REQ-002 SHALL have parameter IW, default `I_INDEX_WIDTH, set index width.
REQ-003 SHALL have parameter WOW, default `I_WO_WIDTH, word-offset width; the line is 2^WOW words.
REQ-004 SHALL have parameter FW, default 2, words per fetch; a power of two, 1..2^WOW.
REQ-005 SHALL have the following ports; one clock; reset is asynchronous and active-high:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- rd_en  in  1  read request
- rd_ready  out  1  read can be accepted
- rd_index  in  IW  read set index
- rd_offset  in  WOW  read word offset
- rd_valid  out  1  read data valid
- rd_data  out  DW*FW  fetched words
- rd_perr  out  1  parity error
- fill_start  in  1  begin line refill
- fill_index  in  IW  refill set index
- fill_offset  in  WOW  critical word offset
- fill_valid  in  1  refill beat valid
- fill_data  in  DW  refill beat data
- fill_ready  out  1  beat can be accepted
- fill_done  out  1  refill complete pulse

Function
REQ-006 SHALL store 2^(IW+WOW) words of DW bits, addressed {index, offset}.
REQ-007 SHALL accept a read when rd_en & rd_ready.
- rd_valid=1 exactly one cycle later.
- rd_data word i (bits i*DW +: DW) = mem[{rd_index, rd_offset aligned down to FW, +i}]; low log2(FW) offset bits ignored.
REQ-008 SHALL hold rd_data and drop rd_valid to 0 in cycles following no accepted read.
REQ-009 SHALL implement FSM IDLE, FILL, DONE:
- IDLE->FILL on fill_start, latching fill_index and fill_offset.
- FILL->DONE on the 2^WOW-th accepted beat.
- DONE->IDLE unconditionally.
REQ-010 SHALL drive rd_ready=1 only in IDLE, and fill_ready=1 only in FILL.
REQ-011 SHALL write fill_data on fill_valid & fill_ready to the latched index at beat offset.
- Beat offset starts at the latched fill_offset and increments modulo 2^WOW (critical-word-first wrap).
REQ-012 SHALL pulse fill_done=1 for the single cycle in DONE.
REQ-013 SHALL ignore fill_start outside IDLE.
REQ-014 On rd_en & fill_start together in IDLE:
- the read SHALL be accepted and return pre-refill contents;
- the FSM SHALL enter FILL in the same cycle.
REQ-015 SHALL hold the beat counter while fill_valid=0 in FILL; gaps between beats are unlimited.

Reset
REQ-016 While rst=1, SHALL asynchronously force: state=IDLE, beat counter=0, rd_valid=0, rd_data=0, rd_perr=0, fill_done=0; hence rd_ready=1, fill_ready=0.
REQ-017 SHALL NOT reset array contents; a refill aborted by rst leaves already-written words written and the rest unchanged.

Configuration
REQ-018 With IDRAM_PARITY_EN defined:
- SHALL store one even-parity bit per word, computed from fill_data;
- rd_perr=1 with rd_valid when any fetched word's parity mismatches.
REQ-019 Without IDRAM_PARITY_EN:
- SHALL store no parity bits;
- rd_perr SHALL be tied to 0.

Structure
REQ-020 SHALL take the FSM state enum and the derived constants (line words, fetch-offset width) from shared package idram_pkg.
REQ-021 SHALL build the array from FW instances of sub-module idram_bank.
- Bank b holds words with offset mod FW = b, so one fetch reads all banks in parallel.
- Each bank: one write port, one synchronous read port.

Verification
REQ-022 Reset during a read: rst pulsed mid-read -> rd_valid=0, rd_data=0, rd_ready=1 immediately, independent of clk.
REQ-023 Critical-word-first refill (WOW=2, FW=2, DW=32): refill index 3 from offset 2 with beats A,B,C,D -> words 2,3,0,1 = A,B,C,D; fill_done pulses one cycle after beat D; a read at offset 1 then returns {B? no: word1,word0}={D,C}.
REQ-024 Beat gaps: fill_valid low for 3 cycles between beats -> counter holds; fill_done after exactly 4 accepted beats.
REQ-025 Simultaneous rd_en and fill_start at the same index -> read returns old data; later read returns the new line.
REQ-026 Read while busy: rd_en held high during FILL -> rd_ready=0, no rd_valid; first acceptance is the cycle after DONE.
REQ-027 Parity (IDRAM_PARITY_EN): force one stored bit flipped -> rd_perr=1 with rd_valid; without the macro -> rd_perr=0.
